mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-access stage between execute and 16-bit word data memory.
// Optional byte loads / read-modify-write byte stores when BYTE_ACCESS_EN is defined.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic        req_bsel,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_rd,
  output logic        dm_wflag,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_datain,
  input  logic [15:0] dm_dataout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_rd
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [15:0] a_addr;
  logic [2:0]  a_rd;
  logic [15:0] din_q;
  logic [15:0] rdat_q;
  logic [2:0]  rrd_q;

  logic        accept;
  logic        req_is_bst;
  logic        rd_to_wr;
  logic [15:0] ld_word;

`ifdef BYTE_ACCESS_EN
  logic        a_we;
  logic        a_byte;
  logic        a_bsel;
  logic [7:0]  a_wb;
  logic [15:0] st_word;

  assign req_is_bst = req_we & req_byte;
  assign rd_to_wr   = a_we & a_byte;

  // Lane extract for byte loads and lane merge for byte stores
  always_comb begin
    ld_word = dm_dataout;
    st_word = dm_dataout;
    if (a_byte) begin
      if (a_bsel) begin
        ld_word = {8'h00, dm_dataout[15:8]};
        st_word = {a_wb, dm_dataout[7:0]};
      end else begin
        ld_word = {8'h00, dm_dataout[7:0]};
        st_word = {dm_dataout[15:8], a_wb};
      end
    end
  end

  // Byte-access request fields, captured on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_we   <= 1'b0;
      a_byte <= 1'b0;
      a_bsel <= 1'b0;
      a_wb   <= 8'h00;
    end else if (accept) begin
      a_we   <= req_we;
      a_byte <= req_byte;
      a_bsel <= req_bsel;
      a_wb   <= req_wdata[7:0];
    end
  end
`else
  logic unused_byte;

  assign unused_byte = ^{req_byte, req_bsel};
  assign req_is_bst  = 1'b0;
  assign rd_to_wr    = 1'b0;
  assign ld_word     = dm_dataout;
`endif

  assign accept    = req_valid & (state == IDLE);
  assign dm_addr   = a_addr;
  assign dm_datain = din_q;
  assign rsp_data  = rdat_q;
  assign rsp_rd    = rrd_q;

  // State register; reset aborts any operation at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake / write-strobe outputs
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    dm_wflag  = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          if (req_we && !req_is_bst) state_nx = WRITE;
          else                       state_nx = READ;
        end
      end
      READ: begin
        if (rd_to_wr) state_nx = WRITE;
        else          state_nx = RESP;
      end
      WRITE: begin
        dm_wflag = 1'b1;
        state_nx = IDLE;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address/tag latch, write data, and held load response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_addr <= 16'h0000;
      a_rd   <= 3'd0;
      din_q  <= 16'h0000;
      rdat_q <= 16'h0000;
      rrd_q  <= 3'd0;
    end else begin
      if (accept) begin
        a_addr <= req_addr;
        a_rd   <= req_rd;
        if (req_we && !req_is_bst) din_q <= req_wdata;
      end
      if (state == READ) begin
        if (rd_to_wr) begin
`ifdef BYTE_ACCESS_EN
          din_q <= st_word;
`endif
        end else begin
          rdat_q <= ld_word;
          rrd_q  <= a_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table plus hand sequences for mem_access_ctrl.
// Holds a 256-word memory model behind the data-memory port.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic        req_bsel;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_rd;
  logic        dm_wflag;
  logic [15:0] dm_addr;
  logic [15:0] dm_datain;
  logic [15:0] dm_dataout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [15:0] mem [0:255] = '{default: 16'h0000};

  always #5 clk = ~clk;

  assign dm_dataout = mem[dm_addr[7:0]];

  always @(posedge clk) begin
    if (dm_wflag) begin
      mem[dm_addr[7:0]] <= dm_datain;
      wr_count <= wr_count + 1;
    end
  end

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte), .req_bsel(req_bsel),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dm_wflag(dm_wflag), .dm_addr(dm_addr), .dm_datain(dm_datain),
    .dm_dataout(dm_dataout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd)
  );

  typedef struct {
    logic        we;
    logic        byt;
    logic        bsel;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  rd;
    logic [15:0] exp;
    int          done;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic byt, input logic bsel,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [2:0] rd);
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = byt;
    req_bsel  = bsel;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int done, nw, rk;
    logic [15:0] wa, wd, rdat;
    logic [2:0] rrd;
    int wc0;

    tv[0]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 3'd0, 16'hBEEF, 2};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 3'd5, 16'hBEEF, 3};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234, 3'd0, 16'h1234, 2};
`ifdef BYTE_ACCESS_EN
    tv[3]  = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h00AB, 3'd0, 16'hAB34, 3};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 3'd3, 16'h0034, 3};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 3'd7, 16'hAB34, 3};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h1255, 3'd0, 16'hAB55, 3};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 3'd2, 16'h00AB, 3};
`else
    tv[3]  = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h00AB, 3'd0, 16'h00AB, 2};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 3'd3, 16'h00AB, 3};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 3'd7, 16'h00AB, 3};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h1255, 3'd0, 16'h1255, 2};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 3'd2, 16'h1255, 3};
`endif
    tv[8]  = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'hFFFF, 3'd0, 16'hFFFF, 2};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 3'd1, 16'hFFFF, 3};
    tv[10] = '{1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 3'd4, 16'h0000, 3};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_bsel  = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    req_rd    = 3'd0;
    rsp_ready = 1'b1;

    @(negedge clk);
    chk("rst_wflag", 32'(dm_wflag), 0);
    chk("rst_addr", 32'(dm_addr), 0);
    chk("rst_datain", 32'(dm_datain), 0);
    chk("rst_rvalid", 32'(rsp_valid), 0);
    chk("rst_rdata", 32'(rsp_data), 0);
    chk("rst_rrd", 32'(rsp_rd), 0);
    chk("rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 1);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      done = -1; nw = 0; rk = -1;
      wa = 16'h0; wd = 16'h0; rdat = 16'h0; rrd = 3'd0;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 1);
      issue(tv[i].we, tv[i].byt, tv[i].bsel, tv[i].addr,
            tv[i].wdata, tv[i].rd);
      for (int k = 1; k <= 10; k++) begin
        if (dm_wflag) begin
          nw++; wa = dm_addr; wd = dm_datain;
        end
        if (rsp_valid && rk < 0) begin
          rk = k; rdat = rsp_data; rrd = rsp_rd;
        end
        if (req_ready) begin
          done = k;
          break;
        end
        @(negedge clk);
      end
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tv[i].done));
      if (tv[i].we) begin
        chk($sformatf("v%0d_nwr", i), 32'(nw), 1);
        chk($sformatf("v%0d_waddr", i), 32'(wa), 32'(tv[i].addr));
        chk($sformatf("v%0d_wdata", i), 32'(wd), 32'(tv[i].exp));
        chk($sformatf("v%0d_mem", i), 32'(mem[tv[i].addr[7:0]]),
            32'(tv[i].exp));
        chk($sformatf("v%0d_norsp", i), 32'(rk), 32'hFFFF_FFFF);
      end else begin
        chk($sformatf("v%0d_nwr", i), 32'(nw), 0);
        chk($sformatf("v%0d_rspcyc", i), 32'(rk), 2);
        chk($sformatf("v%0d_rdata", i), 32'(rdat), 32'(tv[i].exp));
        chk($sformatf("v%0d_rrd", i), 32'(rrd), 32'(tv[i].rd));
      end
    end

    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 3'd5);
    chk("bp_read_valid", 32'(rsp_valid), 0);
    chk("bp_read_ready", 32'(req_ready), 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 1);
      chk($sformatf("bp%0d_data", k), 32'(rsp_data), 32'hBEEF);
      chk($sformatf("bp%0d_rd", k), 32'(rsp_rd), 5);
      chk($sformatf("bp%0d_ready", k), 32'(req_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_ready", 32'(req_ready), 1);
    chk("bp_rel_valid", 32'(rsp_valid), 0);

    wc0 = wr_count;
    issue(1'b1, 1'b0, 1'b0, 16'h0040, 16'h1111, 3'd0);
    chk("rw_wflag_pre", 32'(dm_wflag), 1);
    rst = 1'b1;
    #1;
    chk("rw_wflag", 32'(dm_wflag), 0);
    chk("rw_addr", 32'(dm_addr), 0);
    chk("rw_datain", 32'(dm_datain), 0);
    chk("rw_rdata", 32'(rsp_data), 0);
    chk("rw_rrd", 32'(rsp_rd), 0);
    chk("rw_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_nowrite", 32'(wr_count), 32'(wc0));
    chk("rw_mem", 32'(mem[8'h40]), 0);
    chk("rw_idle", 32'(req_ready), 1);

`ifdef BYTE_ACCESS_EN
    wc0 = wr_count;
    issue(1'b1, 1'b1, 1'b1, 16'h0020, 16'h00CD, 3'd0);
    chk("rmw_read_wflag", 32'(dm_wflag), 0);
    chk("rmw_read_ready", 32'(req_ready), 0);
    rst = 1'b1;
    #1;
    chk("rmw_rst_wflag", 32'(dm_wflag), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_nowrite", 32'(wr_count), 32'(wc0));
    chk("rmw_mem", 32'(mem[8'h20]), 32'hAB55);
    chk("rmw_idle", 32'(req_ready), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
